sal_fifo_vr: RTL and testbench

SAL_FIFO_VR -- requirements
Module: sal_fifo_vr

---
 rtl/sal_fifo_vr.sv | 123 ++++++++++++
 tb/tb_sal_fifo_vr.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/sal_fifo_vr.sv
// sal_fifo_vr: synchronous first-word-fall-through FIFO with valid/ready
// handshakes on both sides, registered occupancy, programmable
// almost-full/almost-empty flags and an optional occupancy high-water mark.
//
// Handshake rule (both sides): a transfer happens on a rising clk edge
// exactly when valid and ready are both high. Valid does not wait for
// ready. s_ready_o and m_valid_o come straight from flops. s_ready_o does
// not look at m_ready_i, so a full FIFO refuses a push even while it is
// being popped.
//
// Optional feature: define SAL_FIFO_VR_PEAK_EN to build the peak-occupancy
// register behind peak_o. Without the macro, peak_o is tied to zero.
module sal_fifo_vr #(
    parameter int DEPTH_LG2  = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush_i,
    input  logic                  s_valid_i,
    output logic                  s_ready_o,
    input  logic [DATA_WIDTH-1:0] s_data_i,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic [DATA_WIDTH-1:0] m_data_o,
    input  logic [DEPTH_LG2:0]    afull_thres_i,
    input  logic [DEPTH_LG2:0]    aempty_thres_i,
    output logic                  afull_o,
    output logic                  aempty_o,
    output logic [DEPTH_LG2:0]    count_o,
    output logic [DEPTH_LG2:0]    peak_o
);

    localparam int PW    = DEPTH_LG2 + 1;
    localparam int DEPTH = 1 << DEPTH_LG2;

    // Storage is deliberately left without a reset.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0] wr_ptr, rd_ptr, wr_nxt, rd_nxt;
    logic [PW-1:0] count_q, count_nxt;
    logic          s_ready_q, m_valid_q;
    logic          afull_q, aempty_q;
    logic          full_nxt, empty_nxt;
    logic          push, pop;

    assign push = s_valid_i & s_ready_q;
    assign pop  = m_valid_q & m_ready_i;

    // Next pointers and occupancy. A flush overrides any push or pop.
    always_comb begin
        wr_nxt    = wr_ptr + PW'(push);
        rd_nxt    = rd_ptr + PW'(pop);
        count_nxt = count_q + PW'(push) - PW'(pop);
        if (flush_i) begin
            wr_nxt    = '0;
            rd_nxt    = '0;
            count_nxt = '0;
        end
    end

    // The FIFO is full when the wrap bits differ and the index bits match.
    // It is empty when the two pointers are identical.
    always_comb begin
        full_nxt  = (wr_nxt[DEPTH_LG2] != rd_nxt[DEPTH_LG2]) &&
                    (wr_nxt[DEPTH_LG2-1:0] == rd_nxt[DEPTH_LG2-1:0]);
        empty_nxt = (wr_nxt == rd_nxt);
    end

    // Write the accepted payload into the slot at the write index.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[DEPTH_LG2-1:0]] <= s_data_i;
        end
    end

    // Register the pointers, occupancy, handshake flags and threshold flags.
    // The thresholds are compared against the next-state count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
            s_ready_q <= 1'b1;
            m_valid_q <= 1'b0;
            afull_q   <= 1'b0;
            aempty_q  <= 1'b1;
        end else begin
            wr_ptr    <= wr_nxt;
            rd_ptr    <= rd_nxt;
            count_q   <= count_nxt;
            s_ready_q <= ~full_nxt;
            m_valid_q <= ~empty_nxt;
            afull_q   <= (count_nxt >= afull_thres_i);
            aempty_q  <= (count_nxt <= aempty_thres_i);
        end
    end

`ifdef SAL_FIFO_VR_PEAK_EN
    logic [PW-1:0] peak_q;

    // Track the largest occupancy seen since the last reset or flush.
    always_ff @(posedge clk) begin
        if (!rst_n || flush_i) begin
            peak_q <= '0;
        end else if (count_nxt > peak_q) begin
            peak_q <= count_nxt;
        end
    end

    assign peak_o = peak_q;
`else
    assign peak_o = '0;
`endif

    assign s_ready_o = s_ready_q;
    assign m_valid_o = m_valid_q;
    assign m_data_o  = mem[rd_ptr[DEPTH_LG2-1:0]];
    assign afull_o   = afull_q;
    assign aempty_o  = aempty_q;
    assign count_o   = count_q;

endmodule

// File: tb/tb_sal_fifo_vr.sv
// Bench for sal_fifo_vr (DEPTH_LG2=2, DATA_WIDTH=8).
// A queue-based reference model follows every clock edge. A negedge
// process compares every DUT output against the model. Directed sequences
// add hand-computed literal checks, and a randomized phase follows them.
module tb_sal_fifo_vr;

    localparam int LG = 2;
    localparam int W  = 8;
    localparam int D  = 4;

    // ---------------- clock / reset / DUT ----------------
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         flush_i = 1'b0;
    logic         s_valid_i = 1'b0;
    logic         s_ready_o;
    logic [W-1:0] s_data_i = '0;
    logic         m_valid_o;
    logic         m_ready_i = 1'b0;
    logic [W-1:0] m_data_o;
    logic [LG:0]  afull_thres_i = 3'd3;
    logic [LG:0]  aempty_thres_i = 3'd1;
    logic         afull_o, aempty_o;
    logic [LG:0]  count_o, peak_o;

    always #5 clk = ~clk;

    sal_fifo_vr #(.DEPTH_LG2(LG), .DATA_WIDTH(W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush_i        (flush_i),
        .s_valid_i      (s_valid_i),
        .s_ready_o      (s_ready_o),
        .s_data_i       (s_data_i),
        .m_valid_o      (m_valid_o),
        .m_ready_i      (m_ready_i),
        .m_data_o       (m_data_o),
        .afull_thres_i  (afull_thres_i),
        .aempty_thres_i (aempty_thres_i),
        .afull_o        (afull_o),
        .aempty_o       (aempty_o),
        .count_o        (count_o),
        .peak_o         (peak_o)
    );

    // ---------------- scoreboard / model state ----------------
    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];
    int  exp_peak = 0;
    bit  exp_afull = 1'b0;
    bit  exp_aempty = 1'b1;
    bit  check_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one edge of the FIFO rules to the model, using the inputs and
    // thresholds that were present at that edge.
    task automatic model_step();
        bit push, pop;
        if (!rst_n) begin
            exp_q.delete();
            exp_peak   = 0;
            exp_afull  = 1'b0;
            exp_aempty = 1'b1;
        end else begin
            if (flush_i) begin
                exp_q.delete();
                exp_peak = 0;
            end else begin
                push = s_valid_i && (exp_q.size() < D);
                pop  = m_ready_i && (exp_q.size() > 0);
                if (pop) void'(exp_q.pop_front());
                if (push) exp_q.push_back(s_data_i);
                if (exp_q.size() > exp_peak) exp_peak = exp_q.size();
            end
            exp_afull  = (exp_q.size() >= int'(afull_thres_i));
            exp_aempty = (exp_q.size() <= int'(aempty_thres_i));
        end
    endtask

    // Drive one cycle of inputs, advance the model at the edge, settle.
    task automatic cycle(input logic r, input logic f, input logic sv,
                         input logic [W-1:0] d, input logic mr);
        rst_n = r; flush_i = f; s_valid_i = sv; s_data_i = d; m_ready_i = mr;
        @(posedge clk);
        model_step();
        #1;
    endtask

    // Compare every output against the model, away from the active edge.
    always @(negedge clk) begin
        if (check_en) begin
            chk("count_o", 32'(count_o), 32'(exp_q.size()));
            chk("s_ready_o", 32'(s_ready_o), 32'(exp_q.size() < D));
            chk("m_valid_o", 32'(m_valid_o), 32'(exp_q.size() > 0));
            if (exp_q.size() > 0) chk("m_data_o", 32'(m_data_o), 32'(exp_q[0]));
            chk("afull_o", 32'(afull_o), 32'(exp_afull));
            chk("aempty_o", 32'(aempty_o), 32'(exp_aempty));
`ifdef SAL_FIFO_VR_PEAK_EN
            chk("peak_o", 32'(peak_o), 32'(exp_peak));
`else
            chk("peak_o", 32'(peak_o), 32'd0);
`endif
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int p_push, p_pop;

        // Reset state.
        cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        check_en = 1'b1;
        chk("rst_count", 32'(count_o), 32'd0);
        chk("rst_s_ready", 32'(s_ready_o), 32'd1);
        chk("rst_m_valid", 32'(m_valid_o), 32'd0);
        chk("rst_afull", 32'(afull_o), 32'd0);
        chk("rst_aempty", 32'(aempty_o), 32'd1);
        chk("rst_peak", 32'(peak_o), 32'd0);

        // An entry pushed into an empty FIFO is visible one cycle later.
        cycle(1'b1, 1'b0, 1'b1, 8'hA5, 1'b0);
        chk("lat_valid", 32'(m_valid_o), 32'd1);
        chk("lat_data", 32'(m_data_o), 32'hA5);
        cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        chk("lat_drained", 32'(m_valid_o), 32'd0);

        // Fill to full; the fifth push must be ignored.
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b1, 8'(8'h11 + i), 1'b0);
        chk("full_s_ready", 32'(s_ready_o), 32'd0);
        chk("full_count", 32'(count_o), 32'd4);
        chk("full_afull", 32'(afull_o), 32'd1);
        cycle(1'b1, 1'b0, 1'b1, 8'h15, 1'b0);
        chk("full_ignored", 32'(count_o), 32'd4);

        // Drain in order.
        for (int i = 0; i < 4; i++) begin
            chk("drain_data", 32'(m_data_o), 32'(8'h11 + i));
            cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        end
        chk("drain_valid", 32'(m_valid_o), 32'd0);
        chk("drain_aempty", 32'(aempty_o), 32'd1);
        chk("drain_count", 32'(count_o), 32'd0);

        // Peak after fill to 3 and drain to 0, starting from a flush.
        cycle(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b1, 8'(8'h30 + i), 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
`ifdef SAL_FIFO_VR_PEAK_EN
        chk("peak_fill3", 32'(peak_o), 32'd3);
`else
        chk("peak_fill3", 32'(peak_o), 32'd0);
`endif

        // A flush that coincides with a push discards everything.
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b1, 8'(8'h40 + i), 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 8'h77, 1'b0);
        chk("flush_count", 32'(count_o), 32'd0);
        chk("flush_valid", 32'(m_valid_o), 32'd0);
        chk("flush_peak", 32'(peak_o), 32'd0);

        // Steady push and pop with two entries resident, across the wrap.
        cycle(1'b1, 1'b0, 1'b1, 8'h50, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 8'h51, 1'b0);
        for (int i = 0; i < 10; i++) begin
            chk("stream_data", 32'(m_data_o), 32'(8'h50 + i));
            cycle(1'b1, 1'b0, 1'b1, 8'(8'h52 + i), 1'b1);
            chk("stream_count", 32'(count_o), 32'd2);
        end

        // Randomized traffic, with occasional reset, flush and threshold changes.
        p_push = 50; p_pop = 50;
        for (int n = 0; n < 3000; n++) begin
            if (n % 150 == 0) begin
                p_push = $urandom_range(10, 90);
                p_pop  = $urandom_range(10, 90);
            end
            if (n % 17 == 0) begin
                afull_thres_i  = 3'($urandom_range(0, 4));
                aempty_thres_i = 3'($urandom_range(0, 4));
            end
            cycle($urandom_range(0, 199) != 0,
                  $urandom_range(0, 99) == 0,
                  $urandom_range(0, 99) < p_push,
                  8'($urandom),
                  $urandom_range(0, 99) < p_pop);
        end

        @(negedge clk);
        check_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
